vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA controller. It generates hsync, vsync and data-enable for any resolution and porch set, with programmable sync polarity. It issues a pixel-coordinate request a configurable number of cycles ahead of display, so pixel sources with different pipeline depths fit without edits. It sits between the pixel-clock PLL and the picture generator; frame/line strobes let downstream logic align to the raster.

Parameters:
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch
H_VALID, 640, active pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch
V_VALID, 480, active lines
V_FRONT, 10, vertical front porch
CNT_W, 12, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
RGB_W, 16, pixel data width
REQ_LEAD, 1, cycles pix_req/pix_x lead de; legal 0..H_BACK
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level

Ports:
vga_clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset, sampled on vga_clk rising edge
en  in  1  timing enable; start/stop honoured only at frame boundary
pix_data  in  RGB_W  pixel from source, for coordinate issued REQ_LEAD cycles earlier
pix_req  out  1  pix_x/pix_y valid, source must respond in REQ_LEAD cycles
pix_x  out  CNT_W  requested column; all-ones when pix_req=0
pix_y  out  CNT_W  requested row; all-ones when pix_req=0
vga_rgb  out  RGB_W  display data; 0 when de=0
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
de  out  1  active video
frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0 of each running frame
line_start  out  1  one-cycle pulse at h_cnt=0 of every line while running

Behaviour:
- H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (800 default); V_TOTAL likewise (525). H_ACT = H_SYNC+H_BACK (144); V_ACT = V_SYNC+V_BACK (35).
- Line order: sync, back porch, active, front porch. Counter 0 is the first sync cycle.
- State machine: IDLE, RUN, STOPPING.
  - IDLE: counters held at 0; outputs idle.
  - IDLE->RUN when en=1; the first RUN cycle has h_cnt=0, v_cnt=0.
  - RUN->STOPPING when en=0. STOPPING keeps counting and returns to RUN if en rises again.
  - STOPPING->IDLE when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 (end of frame). A frame is never truncated.
- Counters (RUN/STOPPING):
  - h_cnt increments each cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0.
- Outputs are combinational decode of registered counters and state, so there is no extra pipeline:
  - hsync = HS_POL when h_cnt < H_SYNC, else ~HS_POL.
  - vsync = VS_POL when v_cnt < V_SYNC, else ~VS_POL.
  - de = 1 when H_ACT <= h_cnt < H_ACT+H_VALID and V_ACT <= v_cnt < V_ACT+V_VALID.
  - pix_req: same window as de, shifted earlier by REQ_LEAD in h only.
  - pix_x = h_cnt-(H_ACT-REQ_LEAD); pix_y = v_cnt-V_ACT while pix_req.
  - vga_rgb = pix_data when de, else 0.
  - REQ_LEAD=0: pix_req equals de and the source must be combinational.
- Idle/reset output values:
  - hsync=~HS_POL, vsync=~VS_POL.
  - de, pix_req, frame_start, line_start = 0.
  - vga_rgb = 0; pix_x, pix_y = all-ones.
- rst_n low on any edge: state->IDLE and counters->0 on that edge, including mid-frame. Outputs take idle values the same cycle the registers clear.
- en toggling within a frame has no visible effect except cancelling a pending stop.

Test Plan:
- Reset release with en=1, defaults -> frame_start=1 on first RUN cycle; hsync low for h=0..95, high at h=96; line_start every 800 cycles; vsync low for lines 0..1.
- Active window -> first de at h=144, v=35, pix_x=0 at h=143 (REQ_LEAD=1); last de at h=783, v=514; 640x480=307200 de cycles per 420000-cycle frame; pix_x, pix_y all-ones outside.
- Data path: source returning {pix_y[7:0], pix_x[7:0]} registered -> vga_rgb equals {y,x} of the displayed pixel every de cycle; vga_rgb=0 when de=0.
- en dropped at line 100 -> frame completes to h=799, v=524, then idle values; en re-raised during STOPPING -> no gap, next frame_start at the normal time.
- rst_n low mid-line (h=500, v=200) for 3 cycles -> idle values and counters 0 from the next edge; restart produces a full frame from h=0.
- Alt parameters (800x600: 128/88/800/40, 4/23/600/1, HS_POL=VS_POL=1, REQ_LEAD=3) -> H_TOTAL=1056, V_TOTAL=628; hsync high for h<128; first pix_req at h=213; first de at h=216, v=27.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with a lead-ahead pixel request and frame/line strobes
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_VALID  = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_VALID  = 480,
    parameter int V_FRONT  = 10,
    parameter int CNT_W    = 12,
    parameter int RGB_W    = 16,
    parameter int REQ_LEAD = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [RGB_W-1:0] pix_data,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    output logic             line_start
);
    localparam int H_ACT = H_SYNC + H_BACK;
    localparam int V_ACT = V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACT + H_VALID + H_FRONT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACT + V_VALID + V_FRONT - 1);
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_B   = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] HA_E   = CNT_W'(H_ACT + H_VALID);
    localparam logic [CNT_W-1:0] HR_B   = CNT_W'(H_ACT - REQ_LEAD);
    localparam logic [CNT_W-1:0] HR_E   = CNT_W'(H_ACT + H_VALID - REQ_LEAD);
    localparam logic [CNT_W-1:0] VA_B   = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] VA_E   = CNT_W'(V_ACT + V_VALID);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             run, h_wrap, eof, v_act;

    assign run    = state != IDLE;
    assign h_wrap = h_cnt == H_LAST;
    assign eof    = h_wrap && v_cnt == V_LAST;
    assign v_act  = v_cnt >= VA_B && v_cnt < VA_E;

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nx;
            if (run) begin
                h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
                if (h_wrap)
                    v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
            end
        end
    end

    // counters already sit at 0 in IDLE, so leaving it needs no counter load
    always_comb begin
        state_nx    = state == IDLE ? (en ? RUN : IDLE) :
                      state == RUN  ? (en ? RUN : STOPPING) :
                      (en ? RUN : (eof ? IDLE : STOPPING));
        hsync       = ~HS_POL;
        vsync       = ~VS_POL;
        de          = 1'b0;
        pix_req     = 1'b0;
        pix_x       = '1;
        pix_y       = '1;
        vga_rgb     = '0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        if (run) begin
            hsync       = h_cnt < HS_E ? HS_POL : ~HS_POL;
            vsync       = v_cnt < VS_E ? VS_POL : ~VS_POL;
            de          = v_act && h_cnt >= HA_B && h_cnt < HA_E;
            pix_req     = v_act && h_cnt >= HR_B && h_cnt < HR_E;
            pix_x       = pix_req ? h_cnt - HR_B : '1;
            pix_y       = pix_req ? v_cnt - VA_B : '1;
            vga_rgb     = de ? pix_data : '0;
            frame_start = h_cnt == '0 && v_cnt == '0;
            line_start  = h_cnt == '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on default, 800x600 and a tiny raster instance
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic rst0, en0, req0, hs0, vs0, de0, fs0, ls0;
    logic [11:0] x0, y0;
    logic [15:0] pd0, rgb0;
    logic rst1, en1, req1, hs1, vs1, de1, fs1, ls1;
    logic [11:0] x1, y1;
    logic [15:0] pd1 = 16'hA5A5;
    logic [15:0] rgb1;
    logic rst2, en2, req2, hs2, vs2, de2, fs2, ls2;
    logic [7:0] x2, y2;
    logic [15:0] s2a, pd2, rgb2;

    vga_timing_gen d0 (
        .vga_clk(clk), .rst_n(rst0), .en(en0), .pix_data(pd0), .pix_req(req0),
        .pix_x(x0), .pix_y(y0), .vga_rgb(rgb0), .hsync(hs0), .vsync(vs0), .de(de0),
        .frame_start(fs0), .line_start(ls0)
    );

    vga_timing_gen #(
        .H_SYNC(128), .H_BACK(88), .H_VALID(800), .H_FRONT(40),
        .V_SYNC(4), .V_BACK(23), .V_VALID(600), .V_FRONT(1),
        .REQ_LEAD(3), .HS_POL(1'b1), .VS_POL(1'b1)
    ) d1 (
        .vga_clk(clk), .rst_n(rst1), .en(en1), .pix_data(pd1), .pix_req(req1),
        .pix_x(x1), .pix_y(y1), .vga_rgb(rgb1), .hsync(hs1), .vsync(vs1), .de(de1),
        .frame_start(fs1), .line_start(ls1)
    );

    vga_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_VALID(4), .V_FRONT(1),
        .CNT_W(8), .REQ_LEAD(2), .HS_POL(1'b0), .VS_POL(1'b1)
    ) d2 (
        .vga_clk(clk), .rst_n(rst2), .en(en2), .pix_data(pd2), .pix_req(req2),
        .pix_x(x2), .pix_y(y2), .vga_rgb(rgb2), .hsync(hs2), .vsync(vs2), .de(de2),
        .frame_start(fs2), .line_start(ls2)
    );

    // pixel sources: one register for d0, two for d2, returning {y,x}
    always @(posedge clk) begin
        pd0 <= {y0[7:0], x0[7:0]};
        s2a <= {y2, x2};
        pd2 <= s2a;
    end

    logic [45:0] obs0, obs1;
    logic [37:0] obs2;
    assign obs0 = {hs0, vs0, de0, req0, x0, y0, rgb0, fs0, ls0};
    assign obs1 = {hs1, vs1, de1, req1, x1, y1, rgb1, fs1, ls1};
    assign obs2 = {hs2, vs2, de2, req2, x2, y2, rgb2, fs2, ls2};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [45:0] exp0(input int h, input int v);
        logic d, r;
        d = h >= 144 && h < 784 && v >= 35 && v < 515;
        r = h >= 143 && h < 783 && v >= 35 && v < 515;
        return {h >= 96, v >= 2, d, r, r ? 12'(h - 143) : 12'hFFF, r ? 12'(v - 35) : 12'hFFF,
                d ? {8'(v - 35), 8'(h - 144)} : 16'h0, h == 0 && v == 0, h == 0};
    endfunction

    function automatic logic [45:0] exp1(input int h, input int v);
        logic d, r;
        d = h >= 216 && h < 1016 && v >= 27 && v < 627;
        r = h >= 213 && h < 1013 && v >= 27 && v < 627;
        return {h < 128, v < 4, d, r, r ? 12'(h - 213) : 12'hFFF, r ? 12'(v - 27) : 12'hFFF,
                d ? 16'hA5A5 : 16'h0, h == 0 && v == 0, h == 0};
    endfunction

    function automatic logic [37:0] exp2(input int h, input int v, input bit run);
        logic d, r;
        if (!run) return {1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 16'h0, 1'b0, 1'b0};
        d = h >= 5 && h < 13 && v >= 3 && v < 7;
        r = h >= 3 && h < 11 && v >= 3 && v < 7;
        return {h >= 2, v == 0, d, r, r ? 8'(h - 3) : 8'hFF, r ? 8'(v - 3) : 8'hFF,
                d ? {8'(v - 3), 8'(h - 5)} : 16'h0, h == 0 && v == 0, h == 0};
    endfunction

    int mh, mv, e2, fs_c, ls_c, de_c;

    task automatic scan2(input int n, input bit run);
        for (int i = 0; i < n; i++) begin
            if (obs2 !== exp2(mh, mv, run)) e2++;
            fs_c += int'(fs2);
            ls_c += int'(ls2);
            de_c += int'(de2);
            if (run) begin
                if (mh == 14) begin
                    mh = 0;
                    mv = (mv + 1) % 8;
                end else mh++;
            end
            step();
        end
    endtask

    task automatic clr2();
        e2 = 0; fs_c = 0; ls_c = 0; de_c = 0;
    endtask

    initial begin
        int e0, e1, fdh0, fdv0, frh0, frx0, last0, dc0, ls0c, fs0c;
        int fdh1, fdv1, frh1, ls1c, fs1c;
        e0 = 0; e1 = 0; fdh0 = -1; fdv0 = -1; frh0 = -1; frx0 = -1; last0 = -1; dc0 = 0;
        ls0c = 0; fs0c = 0; fdh1 = -1; fdv1 = -1; frh1 = -1; ls1c = 0; fs1c = 0;
        rst0 = 0; rst1 = 0; rst2 = 0; en0 = 1; en1 = 1; en2 = 1;
        repeat (3) step();
        check("d0_reset_idle", obs0, {1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'hFFF, 16'h0, 1'b0, 1'b0});
        check("d1_reset_idle", obs1, {1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF, 12'hFFF, 16'h0, 1'b0, 1'b0});
        check("d2_reset_idle", obs2, exp2(0, 0, 1'b0));
        rst0 = 1; rst1 = 1;
        step();
        for (int k = 0; k < 29568; k++) begin
            int h0, v0, h1, v1;
            h0 = k % 800; v0 = k / 800; h1 = k % 1056; v1 = k / 1056;
            if (obs0 !== exp0(h0, v0)) e0++;
            if (obs1 !== exp1(h1, v1)) e1++;
            if (de0 && fdh0 < 0) begin fdh0 = h0; fdv0 = v0; end
            if (req0 && frh0 < 0) begin frh0 = h0; frx0 = int'(x0); end
            if (de0 && v0 == 35) begin last0 = h0; dc0++; end
            if (de1 && fdh1 < 0) begin fdh1 = h1; fdv1 = v1; end
            if (req1 && frh1 < 0) frh1 = h1;
            ls0c += int'(ls0); fs0c += int'(fs0); ls1c += int'(ls1); fs1c += int'(fs1);
            step();
        end
        check("d0_scan_mismatches", e0, 0);
        check("d1_scan_mismatches", e1, 0);
        check("d0_first_de_h", fdh0, 144);
        check("d0_first_de_v", fdv0, 35);
        check("d0_first_req_h", frh0, 143);
        check("d0_first_req_x", frx0, 0);
        check("d0_last_de_h", last0, 783);
        check("d0_line_de_count", dc0, 640);
        check("d0_line_starts", ls0c, 37);
        check("d0_frame_starts", fs0c, 1);
        check("d1_first_req_h", frh1, 213);
        check("d1_first_de_h", fdh1, 216);
        check("d1_first_de_v", fdv1, 27);
        check("d1_line_starts", ls1c, 28);
        check("d1_frame_starts", fs1c, 1);
        rst0 = 0; rst1 = 0;

        clr2(); mh = 0; mv = 0;
        scan2(2, 1'b0);
        rst2 = 1;
        scan2(1, 1'b0);
        check("d2_reset_hold", e2, 0);
        clr2(); mh = 0; mv = 0;
        scan2(120, 1'b1);
        check("d2_frame0", e2, 0);
        check("d2_frame0_fs", fs_c, 1);
        check("d2_frame0_ls", ls_c, 8);
        check("d2_frame0_de", de_c, 32);

        clr2();
        scan2(75, 1'b1);
        en2 = 0;
        scan2(45, 1'b1);
        scan2(20, 1'b0);
        check("d2_stop_frame", e2, 0);
        check("d2_stop_ls", ls_c, 8);
        check("d2_stop_de", de_c, 32);

        en2 = 1;
        scan2(1, 1'b0);
        clr2(); mh = 0; mv = 0;
        scan2(30, 1'b1);
        en2 = 0;
        scan2(15, 1'b1);
        en2 = 1;
        scan2(90, 1'b1);
        check("d2_cancel_stop", e2, 0);
        check("d2_cancel_fs", fs_c, 2);
        check("d2_cancel_ls", ls_c, 9);

        clr2();
        scan2(52, 1'b1);
        rst2 = 0;
        scan2(1, 1'b1);
        scan2(2, 1'b0);
        rst2 = 1;
        scan2(1, 1'b0);
        check("d2_midline_reset", e2, 0);
        clr2(); mh = 0; mv = 0;
        scan2(120, 1'b1);
        check("d2_restart_frame", e2, 0);
        check("d2_restart_fs", fs_c, 1);
        check("d2_restart_ls", ls_c, 8);
        check("d2_restart_de", de_c, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
